// File: rtl/game_pkg.sv
// game_pkg: shared constants for the game datapath.
//   Key codes follow the code space produced by keypad_scan:
//   0-9 are digits, 10 is '*', 11 is '#', 12-15 mean "blank".
//   The segment patterns are active-high, bit order g..a (bit 6 = g, bit 0 = a).
package game_pkg;

  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_HASH  = 4'd11;
  localparam logic [3:0] KEY_BLANK = 4'd15;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_H     = 7'h76;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: purely combinational key-code to 7-segment decoder.
//   code - 4-bit key code (0-9 digit, 10 '*', 11 '#', 12-15 blank)
//   seg  - active-high segments, [6:0] = g..a
//   '*' is displayed as a dash and '#' as an 'H'.
module seg7_decode
  import game_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Table lookup from the key code space onto the segment patterns; every
  // code outside the digit and symbol range shows as blank.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:     seg = SEG_0;
      4'd1:     seg = SEG_1;
      4'd2:     seg = SEG_2;
      4'd3:     seg = SEG_3;
      4'd4:     seg = SEG_4;
      4'd5:     seg = SEG_5;
      4'd6:     seg = SEG_6;
      4'd7:     seg = SEG_7;
      4'd8:     seg = SEG_8;
      4'd9:     seg = SEG_9;
      KEY_STAR: seg = SEG_DASH;
      KEY_HASH: seg = SEG_H;
      default:  seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: right-entry digit buffer driving a multiplexed,
// common-anode 7-segment display.
//   clk, rst  - clock and synchronous active-high reset
//   wr_en     - one-cycle strobe, shifts wr_code in at the rightmost digit
//   wr_code   - 4-bit key code to store
//   clr       - one-cycle strobe, blanks the buffer (wins over wr_en)
//   full      - buffer holds NUM_DIGITS entries
//   len       - number of entered digits
//   digit_n   - active-low one-hot digit select
//   seg_n     - active-low segments, [7] = dp, [6:0] = g..a
// Optional feature macro: SEG_SCAN_BLINK_EN, which blinks the cursor digit
// (the next position to be filled) with a BLINK_DIV-tick half-period.
module seg_scan_display
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 10000,
  parameter int BLINK_DIV  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [3:0]            wr_code,
  input  logic                  clr,
  output logic                  full,
  output logic [3:0]            len,
  output logic [NUM_DIGITS-1:0] digit_n,
  output logic [7:0]            seg_n
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  // Reject configurations the scan and blink counters cannot represent.
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_cfg
    $error("seg_scan_display: unsupported parameter combination");
  end

  logic [3:0]            entry_q [NUM_DIGITS];
  logic [3:0]            entry_d [NUM_DIGITS];
  logic [3:0]            len_q, len_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] digit_n_q, digit_n_d;
  logic [7:0]            seg_n_q, seg_n_d;
  logic                  tick;
  logic                  write_ok;
  logic [6:0]            dec_seg;
  logic                  cursor_off;

  assign full    = (len_q == 4'(NUM_DIGITS));
  assign len     = len_q;
  assign digit_n = digit_n_q;
  assign seg_n   = seg_n_q;

  // Buffer update: clr takes priority, an accepted write shifts everything
  // one place left and drops the new code into the rightmost entry.
  always_comb begin
    entry_d  = entry_q;
    len_d    = len_q;
    write_ok = wr_en && !full && !clr;
    if (clr) begin
      for (int i = 0; i < NUM_DIGITS; i++) entry_d[i] = KEY_BLANK;
      len_d = 4'd0;
    end else if (write_ok) begin
      for (int i = NUM_DIGITS - 1; i >= 1; i--) entry_d[i] = entry_q[i-1];
      entry_d[0] = wr_code;
      len_d      = len_q + 4'd1;
    end
  end

  // Scan timing: the prescaler ticks once every SCAN_DIV cycles, and each
  // tick advances to the next digit, wrapping after the leftmost one.
  always_comb begin
    tick    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  // The decoder looks at the entry for the digit about to be selected so
  // that the select lines and segments switch together on the tick edge.
  seg7_decode u_decode (
    .code (entry_q[idx_d]),
    .seg  (dec_seg)
  );

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;

  // Blink phase generator: counts scan ticks and flips the phase every
  // BLINK_DIV ticks; any buffer change restarts it with the cursor visible.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (write_ok || clr) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (tick) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
    cursor_off = blink_ph_q && !full && (4'(idx_d) == len_q);
  end

  // Blink state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
    end
  end
`else
  assign cursor_off = 1'b0;
`endif

  // Output selection: digit select and segments only change on a tick, and
  // the decimal point is never lit.
  always_comb begin
    digit_n_d = digit_n_q;
    seg_n_d   = seg_n_q;
    if (tick) begin
      digit_n_d = ~(NUM_DIGITS'(1) << idx_d);
      seg_n_d   = cursor_off ? 8'hFF : ~{1'b0, dec_seg};
    end
  end

  // State registers; reset leaves digit 0 selected and all segments dark.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) entry_q[i] <= KEY_BLANK;
      len_q     <= 4'd0;
      presc_q   <= '0;
      idx_q     <= '0;
      digit_n_q <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      seg_n_q   <= 8'hFF;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) entry_q[i] <= entry_d[i];
      len_q     <= len_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      digit_n_q <= digit_n_d;
      seg_n_q   <= seg_n_d;
    end
  end

endmodule
